gcd_feeder: RTL and testbench

GCD_FEEDER -- requirements
Module: gcd_feeder

---
 rtl/gcd_feeder.sv | 186 ++++++++++++++++++
 tb/tb_gcd_feeder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_feeder.sv
// gcd_feeder: buffers operand pairs in a small FIFO and sequences them into
// an external serial-load GCD engine, then returns each result (or a timeout
// error) over a valid/ready result port.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand pair handshake (in_a, in_b)
//   start, data_in          start pulse and serial operand bus to the GCD engine
//   done, gcd_result        completion level and result register of the engine
//   out_valid/out_ready     result handshake (out_data, out_err)
//   dbg_state               current controller state, for observation
//
// Handshake rule for both ports: a transfer happens on a posedge where valid
// and ready are both 1. in_ready depends only on the FIFO fill level, and
// out_valid holds with stable out_data/out_err until the transfer occurs.
module gcd_feeder #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             in_ready,
    output logic             start,
    output logic [WIDTH-1:0] data_in,
    input  logic             done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    input  logic             out_ready,
    output logic [2:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_WAIT   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Operand FIFO
    logic [WIDTH-1:0] fifo_a [DEPTH];
    logic [WIDTH-1:0] fifo_b [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [WIDTH-1:0] head_a, head_b;

    // Holding registers and controller state
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] data_hold;
    logic             done_q;
    logic [TW-1:0]    tmo_cnt;
    logic             done_rise, tmo_hit, head_zero;

    assign in_ready  = (count < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign head_a    = fifo_a[rd_ptr];
    assign head_b    = fifo_b[rd_ptr];

    // Only a fresh low-to-high transition of done counts as completion, so a
    // level left high from an earlier run cannot finish the current one.
    assign done_rise = done && !done_q;
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign head_zero = (head_a == '0) || (head_b == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                // A high done means the engine has not yet been released by
                // its previous run; hold off until it falls.
                if (count != '0 && !done) begin
                    pop       = 1'b1;
                    state_nxt = head_zero ? S_OUT : S_START;
                end
            end
            S_START:  state_nxt = S_LOAD_A;
            S_LOAD_A: state_nxt = S_LOAD_B;
            S_LOAD_B: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_rise || tmo_hit) state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            data_hold <= '0;
            done_q    <= 1'b0;
            tmo_cnt   <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            done_q    <= done;
            data_hold <= data_in;
            if (pop) begin
                a_reg <= head_a;
                b_reg <= head_b;
                // gcd(x, 0) = x; both zero yields 0 through the same select.
                if (head_zero) begin
                    out_data <= (head_a == '0) ? head_b : head_a;
                    out_err  <= 1'b0;
                end
            end
            case (state)
                S_LOAD_B: tmo_cnt <= '0;
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (done_rise) begin
                        out_data <= gcd_result;
                        out_err  <= 1'b0;
                    end else if (tmo_hit) begin
                        out_data <= '0;
                        out_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The serial bus is driven from the holding registers while loading and
    // otherwise keeps the last value it carried.
    always_comb begin
        data_in = data_hold;
        case (state)
            S_START, S_LOAD_A: data_in = a_reg;
            S_LOAD_B:          data_in = b_reg;
            default:           data_in = data_hold;
        endcase
    end

    assign start     = (state == S_START);
    assign out_valid = (state == S_OUT);
    assign dbg_state = state;

endmodule

// File: tb/tb_gcd_feeder.sv
module tb_gcd_feeder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];   // {err, data} of results still owed by the main DUT

  // ---------------- main DUT (TIMEOUT = 1024) ----------------
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_ready, start, done, out_valid, out_err;
  logic        out_ready = 1'b1;
  logic [15:0] data_in, gcd_result, out_data;
  logic [2:0]  dbg_state;

  logic        fake_done = 1'b0, ext_done = 1'b0;
  logic [15:0] fake_res = '0;
  assign done       = fake_done | ext_done;
  assign gcd_result = fake_res;

  gcd_feeder #(.WIDTH(16), .DEPTH(2), .TIMEOUT(1024)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .start(start), .data_in(data_in), .done(done),
    .gcd_result(gcd_result), .out_valid(out_valid), .out_data(out_data),
    .out_err(out_err), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // ---------------- timeout DUT (TIMEOUT = 16, done never rises) ----------------
  logic        in_valid_t = 1'b0;
  logic [15:0] in_a_t = '0, in_b_t = '0;
  logic        in_ready_t, start_t, out_valid_t, out_err_t;
  logic        done_t = 1'b0, out_ready_t = 1'b1;
  logic [15:0] data_in_t, out_data_t;
  logic [15:0] gcd_result_t = 16'hBEEF;
  logic [2:0]  dbg_state_t;

  gcd_feeder #(.WIDTH(16), .DEPTH(2), .TIMEOUT(16)) u_tmo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_t), .in_a(in_a_t), .in_b(in_b_t),
    .in_ready(in_ready_t), .start(start_t), .data_in(data_in_t), .done(done_t),
    .gcd_result(gcd_result_t), .out_valid(out_valid_t), .out_data(out_data_t),
    .out_err(out_err_t), .out_ready(out_ready_t), .dbg_state(dbg_state_t)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural GCD engine for the main DUT ----------------
  // Samples the operand bus in the START, LOAD_A and LOAD_B cycles, then
  // raises done with the true gcd of what it received after fake_delay cycles.
  // In stale mode done is already high from START and dips once before the
  // real completion edge.
  int fake_delay = 20;
  bit stale_mode = 1'b0;
  logic [15:0] ga = '0, gla = '0, gb = '0;

  initial begin
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && start) begin
        aborted = 1'b0;
        ga = data_in;
        if (stale_mode) fake_done = 1'b1;
        @(negedge clk);
        gla = data_in;
        @(negedge clk);
        gb = data_in;
        for (int i = 0; i < fake_delay; i++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          if (stale_mode) begin
            fake_done = 1'b0;
            @(negedge clk);
          end
          fake_done = 1'b1;
          fake_res  = gcd_ref(ga, gb);
          repeat (2) @(negedge clk);
        end
        fake_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard compare process ----------------
  initial begin
    bit          hold_pend;
    logic [16:0] hold_val, e;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("out_hold_valid", out_valid, 1);
          if (out_valid) check("out_hold_value", {out_err, out_data}, hold_val);
        end
        if (out_valid) begin
          if (out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL out_unexpected: got result %0d err %0d, expected no result", out_data, out_err);
            end else begin
              e = exp_q.pop_front();
              checks--;
              check("out_result", {out_err, out_data}, e);
            end
            hold_pend = 1'b0;
          end else begin
            hold_pend = 1'b1;
            hold_val  = {out_err, out_data};
          end
        end else begin
          hold_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b, output int pc);
    bit acc;
    acc = 1'b0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    pc = cyc;
    check("push_accept", acc, 1);
    if (acc) exp_q.push_back({1'b0, gcd_ref(a, b)});
  endtask

  task automatic wait_out(input string name, input int max, output int oc, output int ns, output int sc);
    bit found;
    found = 1'b0;
    ns = 0;
    sc = 0;
    oc = 0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (start) begin
        ns++;
        sc = cyc;
      end
      if (out_valid) begin
        oc = cyc;
        found = 1'b1;
      end
    end
    check({name, "_out_seen"}, found, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int pc, oc, ns, sc, nv, rc, n;
    bit found;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_start", start, 0);
    check("rst_data_in", data_in, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("model_gcd_78_143", gcd_ref(16'd78, 16'd143), 13);
    check("model_gcd_0_55", gcd_ref(16'd0, 16'd55), 55);

    // Timeout: TIMEOUT=16 instance, done never rises.
    settle(1);
    in_a_t = 16'd9;
    in_b_t = 16'd6;
    in_valid_t = 1'b1;
    @(negedge clk);
    check("tmo_in_ready", in_ready_t, 1);
    @(posedge clk);
    #1;
    in_valid_t = 1'b0;
    pc = cyc;
    found = 1'b0;
    ns = 0;
    sc = 0;
    oc = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (start_t) begin
        ns++;
        sc = cyc;
      end
      if (out_valid_t) begin
        oc = cyc;
        found = 1'b1;
      end
    end
    check("tmo_out_seen", found, 1);
    check("tmo_start_count", ns, 1);
    check("tmo_start_latency", sc - pc, 1);
    check("tmo_wait_cycles", oc - sc - 3, 16);
    check("tmo_out_data", out_data_t, 0);
    check("tmo_out_err", out_err_t, 1);
    check("tmo_data_in_hold", data_in_t, 6);
    @(negedge clk);
    check("tmo_out_cleared", out_valid_t, 0);

    // Basic run (78, 143) -> 13, done 20 cycles after LOAD_B.
    settle(3);
    fake_delay = 20;
    push_pair(16'd78, 16'd143, pc);
    wait_out("basic", 300, oc, ns, sc);
    check("basic_start_count", ns, 1);
    check("basic_start_latency", sc - pc, 1);
    check("basic_start_to_valid", oc - sc, 23);
    check("basic_bus_start", ga, 78);
    check("basic_bus_load_a", gla, 78);
    check("basic_bus_load_b", gb, 143);
    check("basic_out_data", out_data, 13);
    check("basic_out_err", out_err, 0);
    check("basic_data_in_hold", data_in, 143);

    // Zero-operand bypass.
    settle(5);
    push_pair(16'd0, 16'd55, pc);
    wait_out("zero_b", 20, oc, ns, sc);
    check("zero_b_no_start", ns, 0);
    check("zero_b_latency", oc - pc, 1);
    check("zero_b_out_data", out_data, 55);
    check("zero_b_out_err", out_err, 0);
    settle(3);
    push_pair(16'd0, 16'd0, pc);
    wait_out("zero_both", 20, oc, ns, sc);
    check("zero_both_latency", oc - pc, 1);
    check("zero_both_out_data", out_data, 0);
    settle(3);
    push_pair(16'd40, 16'd0, pc);
    wait_out("zero_a", 20, oc, ns, sc);
    check("zero_a_out_data", out_data, 40);
    check("zero_data_in_hold", data_in, 143);

    // Back-pressure: consumer stalled, three pairs fill holding regs + FIFO.
    settle(5);
    out_ready = 1'b0;
    fake_delay = 3;
    push_pair(16'd12, 16'd18, pc);
    push_pair(16'd0, 16'd7, pc);
    push_pair(16'd100, 16'd75, pc);
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (in_ready) n++;
    end
    check("bp_in_ready_held_low", n, 0);
    check("bp_out_valid_held", out_valid, 1);
    check("bp_first_result", out_data, 6);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("bp_drained", exp_q.size(), 0);
    check("bp_in_ready_recovered", in_ready, 1);

    // Sticky done from a prior run, then a stale-high done entering WAIT.
    settle(5);
    ext_done = 1'b1;
    stale_mode = 1'b1;
    fake_delay = 6;
    push_pair(16'd21, 16'd14, pc);
    ns = 0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (start) ns++;
      if (out_valid) nv++;
    end
    check("sticky_no_start", ns, 0);
    check("sticky_no_valid", nv, 0);
    @(posedge clk);
    #1;
    ext_done = 1'b0;
    rc = cyc;
    wait_out("sticky", 100, oc, ns, sc);
    check("sticky_start_count", ns, 1);
    check("sticky_release_to_start", sc - rc, 1);
    check("stale_done_ignored", oc - sc, 10);
    check("sticky_out_data", out_data, 7);
    stale_mode = 1'b0;

    // Reset in the middle of WAIT abandons the operation.
    settle(5);
    fake_delay = 20;
    push_pair(16'd30, 16'd45, pc);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (start) found = 1'b1;
    end
    check("rstw_start_seen", found, 1);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstw_start", start, 0);
    check("rstw_data_in", data_in, 0);
    check("rstw_out_valid", out_valid, 0);
    check("rstw_out_data", out_data, 0);
    check("rstw_out_err", out_err, 0);
    check("rstw_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ns = 0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start) ns++;
      if (out_valid) nv++;
    end
    check("rstw_no_valid_after", nv, 0);
    check("rstw_no_start_after", ns, 0);
    check("rstw_in_ready_after", in_ready, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- time limit ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
